// File: rtl/stage_pkg.sv
// Shared stage codes for the multi-cycle core sequencer and its control FSM.
package stage_pkg;

  localparam int STG_W       = 3;
  localparam int STG_IDLE    = 0;
  localparam int STG_FETCH   = 1;
  localparam int STG_DECODE  = 2;
  localparam int STG_EXECUTE = 3;
  localparam int STG_MEM     = 4;
  localparam int STG_WB      = 5;

  // True when a stage code lies inside the active FIRST..LAST window.
  function automatic logic stg_in_range(input int code, input int first, input int last);
    if ((code >= first) && (code <= last)) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/stage_onehot_dec.sv
// Combinational one-hot decoder for a stage code; codes >= N decode to all-zero.
module stage_onehot_dec
  import stage_pkg::*;
#(
  parameter int WIDTH = STG_W,
  parameter int N     = STG_WB + 1
) (
  input  logic [WIDTH-1:0] code,
  output logic [N-1:0]     onehot
);

  // Bit k is set only when the code equals k.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < N; k++) begin
      onehot[k] = (int'(code) == k);
    end
  end

endmodule

// File: rtl/stage_counter.sv
// Free-running pipeline-stage sequencer FIRST..LAST with decoded flags and wrap pulse.
// Optional stage hold input enabled by defining STAGE_CNT_STALL_EN.
module stage_counter
  import stage_pkg::*;
#(
  parameter int WIDTH     = STG_W,
  parameter int FIRST     = STG_FETCH,
  parameter int LAST      = STG_WB,
  parameter int RESET_VAL = STG_IDLE
) (
  input  logic             clk,
  input  logic             reset,
`ifdef STAGE_CNT_STALL_EN
  input  logic             stall,
`endif
  output logic [WIDTH-1:0] out,
  output logic [LAST:0]    stage_oh,
  output logic             first_o,
  output logic             last_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] FIRST_C = WIDTH'(FIRST);
  localparam logic [WIDTH-1:0] LAST_C  = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] next_s;
  logic             wrap_next_s;
  logic             stall_s;
  logic             in_range_s;

`ifdef STAGE_CNT_STALL_EN
  assign stall_s = stall;
`else
  assign stall_s = 1'b0;
`endif

  assign in_range_s = stg_in_range(int'(out), FIRST, LAST);

  // Next stage: out-of-window codes (reset value, illegal) recover to FIRST regardless of stall.
  always_comb begin
    next_s      = out;
    wrap_next_s = 1'b0;
    if (!in_range_s) begin
      next_s      = FIRST_C;
      wrap_next_s = 1'b0;
    end else if (stall_s) begin
      next_s      = out;
      wrap_next_s = 1'b0;
    end else if (out == LAST_C) begin
      next_s      = FIRST_C;
      wrap_next_s = 1'b1;
    end else begin
      next_s      = out + WIDTH'(1);
      wrap_next_s = 1'b0;
    end
  end

  // Stage and wrap registers; reset aborts the sequence immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out    <= RESET_C;
      wrap_o <= 1'b0;
    end else begin
      out    <= next_s;
      wrap_o <= wrap_next_s;
    end
  end

  assign first_o = (out == FIRST_C);
  assign last_o  = (out == LAST_C);

  stage_onehot_dec #(
    .WIDTH(WIDTH),
    .N    (LAST + 1)
  ) u_dec (
    .code  (out),
    .onehot(stage_oh)
  );

endmodule

// File: tb/tb_stage_counter.sv
// Randomized self-checking bench for stage_counter against a stage-list reference model.
module tb_stage_counter;
  import stage_pkg::*;

  localparam int SEQ_LEN = STG_WB - STG_FETCH + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [2:0] out;
  logic [5:0] stage_oh;
  logic       first_o, last_o, wrap_o;
  logic [2:0] out2;
  logic [2:0] stage_oh2;
  logic       first2, last2, wrap2;
`ifdef STAGE_CNT_STALL_EN
  logic       stall_off = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int seq [SEQ_LEN];
  int m_pos;
  bit m_idle;
  int m_idle_val;
  bit m_wrap;
  bit m2_idle;
  bit m2_wrap;

  always #5 clk = ~clk;

  stage_counter dut (
    .clk     (clk),
    .reset   (reset),
`ifdef STAGE_CNT_STALL_EN
    .stall   (stall),
`endif
    .out     (out),
    .stage_oh(stage_oh),
    .first_o (first_o),
    .last_o  (last_o),
    .wrap_o  (wrap_o)
  );

  stage_counter #(.WIDTH(3), .FIRST(2), .LAST(2), .RESET_VAL(0)) dut2 (
    .clk     (clk),
    .reset   (reset),
`ifdef STAGE_CNT_STALL_EN
    .stall   (stall_off),
`endif
    .out     (out2),
    .stage_oh(stage_oh2),
    .first_o (first2),
    .last_o  (last2),
    .wrap_o  (wrap2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_out();
    return m_idle ? m_idle_val : seq[m_pos];
  endfunction

  task automatic model_reset();
    m_idle     = 1'b1;
    m_idle_val = STG_IDLE;
    m_wrap     = 1'b0;
    m2_idle    = 1'b1;
    m2_wrap    = 1'b0;
  endtask

  // Advance the reference by one clock edge, using the inputs the DUT sampled.
  task automatic model_edge();
    if (reset) begin
      if (m_idle) begin
        m_idle = 1'b0;
        m_pos  = 0;
        m_wrap = 1'b0;
      end else if (stall) begin
        m_wrap = 1'b0;
      end else begin
        m_wrap = (m_pos == SEQ_LEN - 1);
        m_pos  = (m_pos + 1) % SEQ_LEN;
      end
      m2_wrap = !m2_idle;
      m2_idle = 1'b0;
    end
  endtask

  task automatic check_all(input string tag, input bit skip_wrap);
    int e;
    int e2;
    logic [5:0] oh;
    logic [2:0] oh2;
    e  = exp_out();
    e2 = m2_idle ? 0 : 2;
    for (int k = 0; k < 6; k++) oh[k] = (e == k);
    for (int k = 0; k < 3; k++) oh2[k] = (e2 == k);
    chk({tag, ":out"}, 8'(out), 8'(e));
    if (!skip_wrap) chk({tag, ":wrap"}, 8'(wrap_o), 8'(m_wrap));
    chk({tag, ":first"}, 8'(first_o), 8'(e == STG_FETCH));
    chk({tag, ":last"}, 8'(last_o), 8'(e == STG_WB));
    chk({tag, ":oh"}, 8'(stage_oh), 8'(oh));
    chk({tag, ":out2"}, 8'(out2), 8'(e2));
    chk({tag, ":wrap2"}, 8'(wrap2), 8'(m2_wrap));
    chk({tag, ":first2"}, 8'(first2), 8'(e2 == 2));
    chk({tag, ":last2"}, 8'(last2), 8'(e2 == 2));
    chk({tag, ":oh2"}, 8'(stage_oh2), 8'(oh2));
  endtask

  task automatic tick(input string tag, input bit skip_wrap);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag, skip_wrap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wraps;
    seq = '{STG_FETCH, STG_DECODE, STG_EXECUTE, STG_MEM, STG_WB};
    m_pos = 0;
    reset = 1'b0;
    stall = 1'b0;
    model_reset();
    #1;
    check_all("reset", 1'b0);

    // 1: held reset, then the first seven stages after release
    repeat (3) tick("t1_rst", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (7) tick("t1_seq", 1'b0);

    // 2: one wrap pulse per five clocks
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      tick("t2_run", 1'b0);
      if (wrap_o) wraps++;
    end
    chk("t2_wrap_count", 8'(wraps), 8'd4);

    // 3: asynchronous reset between edges at EXECUTE
    for (int i = 0; i < 10 && out != 3'(STG_EXECUTE); i++) tick("t3_seek", 1'b0);
    chk("t3_reach", 8'(out), 8'(STG_EXECUTE));
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("t3_async", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick("t3_release", 1'b0);

    // 4: illegal code 7 decodes to nothing and recovers to FETCH
    for (int i = 0; i < 10 && out != 3'(STG_WB); i++) tick("t4_seek", 1'b0);
    chk("t4_reach", 8'(out), 8'(STG_WB));
    @(negedge clk);
    force dut.out = 3'd7;
    m_idle     = 1'b1;
    m_idle_val = 7;
    #1;
    check_all("t4_illegal", 1'b0);
    #1;
    release dut.out;
    tick("t4_recover", 1'b1);
    m_idle_val = STG_IDLE;

`ifdef STAGE_CNT_STALL_EN
    // 5: hold at DECODE, then stall ignored during reset recovery
    for (int i = 0; i < 10 && out != 3'(STG_DECODE); i++) tick("t5_seek", 1'b0);
    chk("t5_reach", 8'(out), 8'(STG_DECODE));
    stall = 1'b1;
    repeat (3) tick("t5_stall", 1'b0);
    stall = 1'b0;
    tick("t5_resume", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    stall = 1'b1;
    #1;
    check_all("t5_rst", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick("t5_rst_stall", 1'b0);
    stall = 1'b0;
`endif

    // Random mix of running, stalling and asynchronous reset pulses
    for (int i = 0; i < 200; i++) begin
`ifdef STAGE_CNT_STALL_EN
      stall = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 15) == 0) begin
        #($urandom_range(1, 3));
        reset = 1'b0;
        model_reset();
        #1;
        check_all("rnd_async", 1'b0);
        repeat ($urandom_range(1, 2)) tick("rnd_hold", 1'b0);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        tick("rnd_run", 1'b0);
      end
    end
    stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
